// File: rtl/dcache_set_assoc_store.sv
// dcache_set_assoc_store: N-way set-associative D-cache tag/data/valid/dirty store.
// Registered lookup, byte-masked store commit, PLRU refill, write-back eviction
// handshake and full-cache flush walker.
// Optional feature macro: DCACHE_PERF_COUNTERS_EN (hit/miss/evict counters).
module dcache_set_assoc_store #(
    parameter int unsigned WAYS            = 2,
    parameter int unsigned LINE_WIDTH      = 6,
    parameter int unsigned DW_OFFSET_WIDTH = 3
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    lookup_valid,
    input  logic [31:0]                             lookup_address,
    output logic                                    resp_valid,
    output logic                                    resp_hit,
    output logic [63:0]                             resp_data,
    input  logic                                    store_valid,
    output logic                                    store_ready,
    input  logic [31:0]                             store_address,
    input  logic [63:0]                             store_data,
    input  logic [7:0]                              store_mask,
    output logic                                    store_done,
    output logic                                    store_hit,
    input  logic                                    refill_valid,
    output logic                                    refill_ready,
    input  logic [31:0]                             refill_address,
    input  logic [64*(1<<DW_OFFSET_WIDTH)-1:0]      refill_block,
    output logic                                    evict_valid,
    input  logic                                    evict_ready,
    output logic [31:0]                             evict_address,
    output logic [64*(1<<DW_OFFSET_WIDTH)-1:0]      evict_block,
    input  logic                                    flush_req,
    output logic                                    flush_busy,
    output logic                                    flush_done
`ifdef DCACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]                             hit_count,
    output logic [31:0]                             miss_count,
    output logic [31:0]                             evict_count
`endif
);

    localparam int unsigned SETS      = 1 << LINE_WIDTH;
    localparam int unsigned BLOCK_DW  = 1 << DW_OFFSET_WIDTH;
    localparam int unsigned LINE_BITS = 64 * BLOCK_DW;
    localparam int unsigned OFF_W     = DW_OFFSET_WIDTH + 3;
    localparam int unsigned TAG_WIDTH = 32 - OFF_W - LINE_WIDTH;
    localparam int unsigned LOG_WAYS  = $clog2(WAYS);
    localparam int unsigned WAY_W     = (LOG_WAYS > 0) ? LOG_WAYS : 1;
    localparam int unsigned PLRU_W    = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int unsigned IDX_W     = LINE_WIDTH + LOG_WAYS;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        EVICT       = 2'd1,
        FLUSH_SCAN  = 2'd2,
        FLUSH_EVICT = 2'd3
    } state_t;

    // Storage: data/tag are not reset; valid/dirty/plru are.
    logic [LINE_BITS-1:0]           data_q [SETS][WAYS];
    logic [TAG_WIDTH-1:0]           tag_q  [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0]      valid_q;
    logic [SETS-1:0][WAYS-1:0]      dirty_q;
    logic [SETS-1:0][PLRU_W-1:0]    plru_q;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               fidx_q, fidx_d;
    logic [LINE_WIDTH-1:0]          ev_set_q, ev_set_d;
    logic [WAY_W-1:0]               ev_way_q, ev_way_d;
    logic                           flush_finish;

    // Address field extraction
    function automatic logic [LINE_WIDTH-1:0] addr_set(input logic [31:0] a);
        return LINE_WIDTH'(a >> OFF_W);
    endfunction

    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [31:0] a);
        return TAG_WIDTH'(a >> (32 - TAG_WIDTH));
    endfunction

    function automatic logic [DW_OFFSET_WIDTH-1:0] addr_dw(input logic [31:0] a);
        return DW_OFFSET_WIDTH'(a >> 3);
    endfunction

    // Walk the PLRU tree (heap order, node n at bit n-1); bit value selects the victim subtree.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        int unsigned       node;
        logic [PLRU_W-1:0] sh;
        node = 1;
        for (int unsigned lvl = 0; lvl < LOG_WAYS; lvl++) begin
            sh   = bits >> (node - 1);
            node = 2 * node + 32'(sh[0]);
        end
        return WAY_W'(node - WAYS);
    endfunction

    // Mark a way as most recently used: every node on its path points away from it.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        int unsigned       node;
        logic [WAY_W-1:0]  wsh;
        logic              dir;
        logic [PLRU_W-1:0] res;
        res  = bits;
        node = 1;
        for (int unsigned lvl = 0; lvl < LOG_WAYS; lvl++) begin
            wsh  = way >> (LOG_WAYS - 1 - lvl);
            dir  = wsh[0];
            res  = (res & ~(PLRU_W'(1) << (node - 1))) | (PLRU_W'(!dir) << (node - 1));
            node = 2 * node + 32'(dir);
        end
        return res;
    endfunction

    logic [LINE_WIDTH-1:0]      l_set, s_set, r_set, f_set;
    logic [TAG_WIDTH-1:0]       l_tag, s_tag, r_tag;
    logic [DW_OFFSET_WIDTH-1:0] l_dw, s_dw;
    logic [WAY_W-1:0]           f_way;

    assign l_set = addr_set(lookup_address);
    assign l_tag = addr_tag(lookup_address);
    assign l_dw  = addr_dw(lookup_address);
    assign s_set = addr_set(store_address);
    assign s_tag = addr_tag(store_address);
    assign s_dw  = addr_dw(store_address);
    assign r_set = addr_set(refill_address);
    assign r_tag = addr_tag(refill_address);
    assign f_set = LINE_WIDTH'(fidx_q >> LOG_WAYS);
    assign f_way = WAY_W'(fidx_q & IDX_W'(WAYS - 1));

    logic             l_hit, s_hit;
    logic [WAY_W-1:0] l_way, s_way;

    // Tag compare for the lookup port
    always_comb begin
        l_hit = 1'b0;
        l_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[l_set][w] && (tag_q[l_set][w] == l_tag)) begin
                l_hit = 1'b1;
                l_way = WAY_W'(w);
            end
        end
    end

    // Tag compare for the store port
    always_comb begin
        s_hit = 1'b0;
        s_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[s_set][w] && (tag_q[s_set][w] == s_tag)) begin
                s_hit = 1'b1;
                s_way = WAY_W'(w);
            end
        end
    end

    logic             r_has_inv;
    logic [WAY_W-1:0] r_inv_way, r_victim;
    logic             r_victim_clean;

    // Refill victim: lowest invalid way, otherwise the PLRU choice
    always_comb begin
        r_has_inv = 1'b0;
        r_inv_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!valid_q[r_set][w] && !r_has_inv) begin
                r_has_inv = 1'b1;
                r_inv_way = WAY_W'(w);
            end
        end
        r_victim       = r_has_inv ? r_inv_way : plru_victim(plru_q[r_set]);
        r_victim_clean = !valid_q[r_set][r_victim] || !dirty_q[r_set][r_victim];
    end

    logic idle;
    logic refill_fire, store_fire, evict_fire;

    assign idle         = (state_q == IDLE);
    assign refill_fire  = reset && idle && refill_valid && r_victim_clean;
    assign refill_ready = refill_fire;
    assign store_ready  = reset && idle && !refill_valid;
    assign store_fire   = store_valid && store_ready;
    assign evict_valid  = (state_q == EVICT) || (state_q == FLUSH_EVICT);
    assign evict_fire   = evict_valid && evict_ready;
    assign flush_busy   = !idle;

    logic [LINE_BITS-1:0] l_line, s_line, ev_line;

    assign l_line  = data_q[l_set][l_way];
    assign ev_line = data_q[ev_set_q][ev_way_q];

    assign evict_address = evict_valid ? {tag_q[ev_set_q][ev_way_q], ev_set_q, OFF_W'(0)} : 32'd0;
    assign evict_block   = evict_valid ? ev_line : '0;

    // Byte-merge the store data into the hit line
    always_comb begin
        s_line = data_q[s_set][s_way];
        for (int unsigned k = 0; k < 8; k++) begin
            if (store_mask[k]) begin
                s_line[64*32'(s_dw) + 8*k +: 8] = store_data[8*k +: 8];
            end
        end
    end

    // FSM state register and flush/evict bookkeeping
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            fidx_q     <= '0;
            ev_set_q   <= '0;
            ev_way_q   <= '0;
            flush_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            fidx_q     <= fidx_d;
            ev_set_q   <= ev_set_d;
            ev_way_q   <= ev_way_d;
            flush_done <= flush_finish;
        end
    end

    // FSM next state: refill eviction, flush scan and flush eviction
    always_comb begin
        state_d      = state_q;
        fidx_d       = fidx_q;
        ev_set_d     = ev_set_q;
        ev_way_d     = ev_way_q;
        flush_finish = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH_SCAN;
                    fidx_d  = '0;
                end else if (refill_valid && !r_victim_clean) begin
                    state_d  = EVICT;
                    ev_set_d = r_set;
                    ev_way_d = r_victim;
                end
            end
            EVICT: begin
                if (evict_ready) state_d = IDLE;
            end
            FLUSH_SCAN: begin
                if (valid_q[f_set][f_way] && dirty_q[f_set][f_way]) begin
                    state_d  = FLUSH_EVICT;
                    ev_set_d = f_set;
                    ev_way_d = f_way;
                end else if (fidx_q == IDX_W'(SETS * WAYS - 1)) begin
                    state_d      = IDLE;
                    flush_finish = 1'b1;
                end else begin
                    fidx_d = fidx_q + IDX_W'(1);
                end
            end
            FLUSH_EVICT: begin
                if (evict_ready) begin
                    if (fidx_q == IDX_W'(SETS * WAYS - 1)) begin
                        state_d      = IDLE;
                        flush_finish = 1'b1;
                    end else begin
                        state_d = FLUSH_SCAN;
                        fidx_d  = fidx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered lookup response and store completion
    always_ff @(posedge clock) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_data  <= '0;
            store_done <= 1'b0;
            store_hit  <= 1'b0;
        end else begin
            resp_valid <= lookup_valid;
            resp_hit   <= lookup_valid && l_hit;
            resp_data  <= (lookup_valid && l_hit) ? l_line[64*32'(l_dw) +: 64] : 64'd0;
            store_done <= store_fire;
            store_hit  <= store_fire && s_hit;
        end
    end

    // Data and tag array writes (refill and store are mutually exclusive)
    always_ff @(posedge clock) begin
        if (refill_fire) begin
            data_q[r_set][r_victim] <= refill_block;
            tag_q[r_set][r_victim]  <= r_tag;
        end else if (store_fire && s_hit) begin
            data_q[s_set][s_way] <= s_line;
        end
    end

    // Valid and dirty state
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (refill_fire) begin
                valid_q[r_set][r_victim] <= 1'b1;
                dirty_q[r_set][r_victim] <= 1'b0;
            end
            if (store_fire && s_hit) dirty_q[s_set][s_way] <= 1'b1;
            if (evict_fire) dirty_q[ev_set_q][ev_way_q] <= 1'b0;
            if (flush_finish) valid_q <= '0;
        end
    end

    // PLRU update: a refill or store to the same set overrides a lookup touch
    always_ff @(posedge clock) begin
        if (!reset) begin
            plru_q <= '0;
        end else begin
            if (lookup_valid && l_hit) plru_q[l_set] <= plru_touch(plru_q[l_set], l_way);
            if (refill_fire) begin
                plru_q[r_set] <= plru_touch(plru_q[r_set], r_victim);
            end else if (store_fire && s_hit) begin
                plru_q[s_set] <= plru_touch(plru_q[s_set], s_way);
            end
        end
    end

`ifdef DCACHE_PERF_COUNTERS_EN
    // Event counters for lookup hits/misses and write-back handshakes
    always_ff @(posedge clock) begin
        if (!reset) begin
            hit_count   <= '0;
            miss_count  <= '0;
            evict_count <= '0;
        end else begin
            if (resp_valid && resp_hit)  hit_count   <= hit_count + 32'd1;
            if (resp_valid && !resp_hit) miss_count  <= miss_count + 32'd1;
            if (evict_fire)              evict_count <= evict_count + 32'd1;
        end
    end
`endif

endmodule
